// File: rtl/lcd_tx_arbiter_if.sv
// Requester and transmitter signals of the shared LCD byte transmitter.
// The arbiter takes the slave view, sources and transmitter the master view.
interface lcd_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_cd;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_cd;
  logic              tx_start;
  logic              tx_done;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              err;

  modport slave (
    input  req_valid, req_data, req_cd, req_last, tx_done,
    output req_ready, tx_data, tx_cd, tx_start, gnt, busy, err
  );

  modport master (
    output req_valid, req_data, req_cd, req_last, tx_done,
    input  req_ready, tx_data, tx_cd, tx_start, gnt, busy, err
  );
endinterface

// File: rtl/lcd_tx_arbiter.sv
// Round-robin arbiter sharing one LCD byte transmitter between NREQ sources,
// with burst locking and transmit/lock timeouts.
module lcd_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4095
) (
  input logic clk,
  input logic rst,
  lcd_tx_arbiter_if.slave arb_io
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      data_q, data_d;
  logic            cd_q, cd_d;

  logic            win_ok;
  logic [IW-1:0]   win;
  logic [IW-1:0]   sel;
  logic [CW-1:0]   cnt_inc;
  logic            cnt_end;

  // Highest-priority candidate is rr_q+1, so scan downwards and keep the last hit.
  always_comb begin
    win_ok = 1'b0;
    win    = rr_q;
    for (int k = NREQ; k >= 1; k--) begin
      if (arb_io.req_valid[(int'(rr_q) + k) % NREQ]) begin
        win_ok = 1'b1;
        win    = IW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign sel     = (state_q == LOCK) ? rr_q : win;
  assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
  assign cnt_end = (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    last_d  = last_q;
    err_d   = err_q;
    start_d = start_q;
    ready_d = '0;
    gnt_d   = gnt_q;
    data_d  = data_q;
    cd_d    = cd_q;
    unique case (state_q)
      IDLE: begin
        if (win_ok) begin
          data_d     = arb_io.req_data[8*sel +: 8];
          cd_d       = arb_io.req_cd[sel];
          last_d     = arb_io.req_last[sel];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          rr_d       = win;
          start_d    = 1'b1;
          cnt_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (arb_io.tx_done) begin
          start_d = 1'b0;
          ready_d = gnt_q;
          lock_d  = ~last_q;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_end) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          lock_d  = 1'b0;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        cnt_d = '0;
        if (lock_q) begin
          state_d = LOCK;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (arb_io.req_valid[rr_q]) begin
          data_d  = arb_io.req_data[8*sel +: 8];
          cd_d    = arb_io.req_cd[sel];
          last_d  = arb_io.req_last[sel];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end else if (cnt_end) begin
          lock_d  = 1'b0;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= IW'(NREQ - 1);
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ready_q <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      cd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      err_q   <= err_d;
      start_q <= start_d;
      ready_q <= ready_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      cd_q    <= cd_d;
    end
  end

  assign arb_io.req_ready = ready_q;
  assign arb_io.tx_data   = data_q;
  assign arb_io.tx_cd     = cd_q;
  assign arb_io.tx_start  = start_q;
  assign arb_io.gnt       = gnt_q;
  assign arb_io.busy      = (state_q != IDLE);
  assign arb_io.err       = err_q;
endmodule
